pbox_iter_engine: RTL and testbench
===================================

Name: pbox_iter_engine

Overview:
- Sequential, parametrised bit-permutation engine for the PRESENT-family datapath.
- Generalises the fixed 64-bit inverse permutation layer to:
  - any block width that is a multiple of 4;
  - runtime-selectable forward or inverse direction;
  - a programmable number of back-to-back applications.
- Operands are accepted over a valid/ready handshake and permuted once per clock in an internal register.
- The result is presented on a valid/ready output port. Sits between the round-key/S-box stages and the round controller.

Parameters:
- WIDTH, 64, block width in bits; must be a multiple of 4 and >= 8, otherwise an elaboration-time error.
- ITER_W, 4, width of the iteration-count input; maximum applications per operation = 2^ITER_W - 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  engine can accept an operand (high only in IDLE).
- mode  input  1  0 = forward permutation, 1 = inverse; sampled on accept.
- iter  input  ITER_W  number of permutation applications; sampled on accept.
- data_in  input  WIDTH  operand; sampled on accept.
- out_valid  output  1  result available (high only in DONE).
- out_ready  input  1  consumer takes result.
- data_out  output  WIDTH  result; equals the internal data register at all times.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Permutations, with N = WIDTH and output bit index P(i) receiving input bit i:
  - Forward: P(i) = (i * N/4) mod (N-1) for i < N-1; P(N-1) = N-1.
  - Inverse: P'(i) = (4*i) mod (N-1) for i < N-1; P'(N-1) = N-1.
  - Both are bijections for every legal N, and P' is the exact inverse of P.
  - Bits 0 and N-1 are fixed points in both modes.
  - For N=64 the inverse maps input bit 1 to bit 4 and input bit 16 to bit 1.
  - Both maps are purely wiring (no logic) inside the one-cycle register update.
- Reset (asynchronous, rst_n low):
  - state = IDLE; data register = 0; count = 0; mode register = 0.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture data_in, mode and iter.
  - If iter == 0, go to DONE (pass-through, data unchanged); otherwise go to RUN with count = iter.
- RUN:
  - Each cycle: data register <= selected permutation of data register; count <= count - 1.
  - When count == 1 in the current cycle, go to DONE after this update.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid = 1; data_out stable.
  - On out_ready: go to IDLE. The data register keeps its value, so data_out holds the last result.
  - No new operand can be accepted in the same cycle as the out_ready handshake.
- Latency, from the accept edge to out_valid asserted: iter + 1 cycles, with iter = 0 giving 1 cycle.
  - Throughput: one operation per iter + 2 cycles when out_ready is held high.
- Backpressure: while out_ready is low in DONE, state, data_out and out_valid hold indefinitely.
- Reset mid-operation: asserting rst_n in any state returns immediately (asynchronously) to reset values; the partial result is discarded.
- mode and iter changing on inputs after accept have no effect on the operation in flight.
- Count arithmetic is unsigned, ITER_W bits; it never underflows because RUN is only entered with count >= 1.

Test Plan:
- WIDTH=64, inverse, iter=1, data_in=64'h0000_0000_0000_0002 -> out_valid 2 cycles after accept, data_out=64'h0000_0000_0000_0010.
- WIDTH=64, forward, iter=1, data_in=64'h0000_0000_0000_0002 -> data_out=64'h0000_0000_0001_0000. Same operand with iter=3 -> data_out=64'h0000_0000_0000_0002, because the forward map has order 3.
- WIDTH=64, forward, iter=3, data_in=64'h0123_4567_89AB_CDEF -> data_out=64'h0123_4567_89AB_CDEF after 4 cycles. Also: forward iter=2 followed by inverse iter=2 on the result returns the original operand.
- iter=0, data_in=64'h8000_0000_0000_0001, either mode -> out_valid 1 cycle after accept, data_out unchanged. Any iter on that operand also returns it unchanged (fixed points).
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and data_out stable and in_ready=0 throughout.
  - Assert rst_n=0 during RUN with iter=15 -> state returns to IDLE, data_out=0, out_valid=0, in_ready=1 without waiting for a clock edge.
- WIDTH=16 instance, random operands -> forward and inverse results are identical (4i mod 15 in both). WIDTH=12 instance against a software reference model of P and P' over 1000 random operands and iter values -> bit-exact match.

Source files
------------

// File: rtl/pbox_iter_engine.sv
// Iterated PRESENT-style bit permutation: forward map i*N/4 mod (N-1), inverse 4*i mod (N-1),
// applied a programmable number of times to an operand taken over valid/ready.
module pbox_iter_engine #(
    parameter int WIDTH  = 64,
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [ITER_W-1:0] iter,
    input  logic [WIDTH-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              busy
);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("pbox_iter_engine: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [WIDTH-1:0]  fwd_perm, inv_perm;
    logic [ITER_W-1:0] count_q, count_d;
    logic              mode_q, mode_d;

    // Both maps are pure rewiring of the data register; bit N-1 is pinned to itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        localparam int FWD_IDX = (i == WIDTH - 1) ? i : (i * (WIDTH / 4)) % (WIDTH - 1);
        localparam int INV_IDX = (i == WIDTH - 1) ? i : (4 * i) % (WIDTH - 1);
        assign fwd_perm[FWD_IDX] = data_q[i];
        assign inv_perm[INV_IDX] = data_q[i];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    mode_d  = mode;
                    count_d = iter;
                    state_d = (iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                data_d  = mode_q ? inv_perm : fwd_perm;
                count_d = count_q - ITER_W'(1);
                if (count_q == ITER_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_pbox_iter_engine.sv
// Bench for pbox_iter_engine: 64/16/12-bit instances run in lockstep on shared controls and are
// compared against a bit-index model of the permutation rules.
module tb_pbox_iter_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  iter = '0;
    logic        out_ready = 1'b0;
    logic [63:0] din64 = '0;
    logic [15:0] din16 = '0;
    logic [11:0] din12 = '0;

    logic        rdy64, ov64, busy64;
    logic        rdy16, ov16, busy16;
    logic        rdy12, ov12, busy12;
    logic [63:0] dout64;
    logic [15:0] dout16;
    logic [11:0] dout12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pbox_iter_engine #(.WIDTH(64), .ITER_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .mode(mode),
        .iter(iter), .data_in(din64), .out_valid(ov64), .out_ready(out_ready),
        .data_out(dout64), .busy(busy64));

    pbox_iter_engine #(.WIDTH(16), .ITER_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16), .mode(mode),
        .iter(iter), .data_in(din16), .out_valid(ov16), .out_ready(out_ready),
        .data_out(dout16), .busy(busy16));

    pbox_iter_engine #(.WIDTH(12), .ITER_W(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy12), .mode(mode),
        .iter(iter), .data_in(din12), .out_valid(ov12), .out_ready(out_ready),
        .data_out(dout12), .busy(busy12));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Moves each bit to its destination index, once per application.
    function automatic logic [63:0] model(input int n, input bit inv, input logic [63:0] d,
                                          input int it);
        logic [63:0] cur;
        logic [63:0] nxt;
        int          dst;
        cur = d;
        for (int k = 0; k < it; k++) begin
            nxt = '0;
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) dst = i;
                else if (inv)   dst = (4 * i) % (n - 1);
                else            dst = (i * (n / 4)) % (n - 1);
                nxt[dst] = cur[i];
            end
            cur = nxt;
        end
        return cur;
    endfunction

    // Presents an operand, then scrambles the inputs and waits for out_valid (sampled on negedges).
    task automatic start_op(input bit m, input logic [3:0] it, input logic [63:0] d64,
                            input logic [15:0] d16, input logic [11:0] d12, output int lat);
        @(negedge clk);
        check("in_ready_idle", {63'd0, rdy64}, 64'd1);
        in_valid = 1'b1;
        mode     = m;
        iter     = it;
        din64    = d64;
        din16    = d16;
        din12    = d12;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        mode  = ~m;
        iter  = 4'($urandom);
        din64 = {$urandom, $urandom};
        din16 = 16'($urandom);
        din12 = 12'($urandom);
        while (!ov64 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Handshakes the result while in_valid is still high; that operand must not be taken.
    task automatic release_op(input logic [63:0] exp64);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", {63'd0, rdy64}, 64'd1);
        check("release_out_valid", {63'd0, ov64}, 64'd0);
        check("release_data_hold", dout64, exp64);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    typedef struct {
        bit          m;
        logic [3:0]  it;
        logic [63:0] d;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int          lat;
        logic [63:0] r64, mid, exp64;
        logic [15:0] r16;
        logic [11:0] r12;
        bit          m;
        logic [3:0]  it;

        vecs[0] = '{1'b1, 4'd1,  64'h0000_0000_0000_0002, 64'h0000_0000_0000_0010};
        vecs[1] = '{1'b0, 4'd1,  64'h0000_0000_0000_0002, 64'h0000_0000_0001_0000};
        vecs[2] = '{1'b0, 4'd3,  64'h0000_0000_0000_0002, 64'h0000_0000_0000_0002};
        vecs[3] = '{1'b0, 4'd3,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1'b0, 4'd0,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        vecs[5] = '{1'b1, 4'd0,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        vecs[6] = '{1'b1, 4'd15, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        vecs[7] = '{1'b1, 4'd1,  64'h0000_0000_0001_0000, 64'h0000_0000_0000_0002};

        #1;
        check("rst_in_ready", {63'd0, rdy64}, 64'd1);
        check("rst_out_valid", {63'd0, ov64}, 64'd0);
        check("rst_busy", {63'd0, busy64}, 64'd0);
        check("rst_data_out", dout64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            start_op(vecs[v].m, vecs[v].it, vecs[v].d, 16'd0, 12'd0, lat);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vecs[v].it) + 64'd1);
            check($sformatf("vec%0d_data", v), dout64, vecs[v].exp);
            release_op(vecs[v].exp);
        end

        // Forward twice then inverse twice restores the operand.
        r64 = 64'h0123_4567_89AB_CDEF;
        start_op(1'b0, 4'd2, r64, 16'd0, 12'd0, lat);
        mid = dout64;
        check("fwd2_data", mid, model(64, 1'b0, r64, 2));
        release_op(mid);
        start_op(1'b1, 4'd2, mid, 16'd0, 12'd0, lat);
        check("fwd2_inv2_roundtrip", dout64, r64);
        release_op(r64);

        // Backpressure: DONE holds for 10 cycles with in_valid asserted.
        r64   = {$urandom, $urandom};
        exp64 = model(64, 1'b1, r64, 5);
        start_op(1'b1, 4'd5, r64, 16'd0, 12'd0, lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, ov64}, 64'd1);
            check("bp_in_ready", {63'd0, rdy64}, 64'd0);
            check("bp_data", dout64, exp64);
        end
        release_op(exp64);

        // Asynchronous reset in the middle of a 15-iteration run.
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 1'b1;
        iter     = 4'd15;
        din64    = 64'hDEAD_BEEF_0123_4567;
        din16    = 16'hBEEF;
        din12    = 12'hABC;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_run_busy", {63'd0, busy64}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, ov64}, 64'd0);
        check("arst_in_ready", {63'd0, rdy64}, 64'd1);
        check("arst_busy", {63'd0, busy64}, 64'd0);
        check("arst_data64", dout64, 64'd0);
        check("arst_data16_12", {36'd0, dout16, dout12}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random operations on all three widths against the model.
        for (int n = 0; n < 1000; n++) begin
            m   = 1'($urandom);
            it  = 4'($urandom_range(0, 15));
            r64 = {$urandom, $urandom};
            r16 = 16'($urandom);
            r12 = 12'($urandom);
            start_op(m, it, r64, r16, r12, lat);
            exp64 = model(64, m, r64, int'(it));
            check("rnd_latency", 64'(lat), 64'(it) + 64'd1);
            check("rnd_w64", dout64, exp64);
            check("rnd_w12", {52'd0, dout12}, model(12, m, {52'd0, r12}, int'(it)));
            check("rnd_w16", {48'd0, dout16}, model(16, m, {48'd0, r16}, int'(it)));
            check("rnd_w16_mode_sym", {48'd0, dout16}, model(16, ~m, {48'd0, r16}, int'(it)));
            check("rnd_small_flags", {58'd0, ov16, busy16, ov12, busy12, rdy16, rdy12},
                  64'b111100);
            release_op(exp64);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
